// File: rtl/cpu_ctrl.sv
// cpu_ctrl: multi-cycle instruction sequencer (IDLE/FETCH/DECODE/EXEC/WB/HALT).
// Drives fetch/decode/execute/writeback strobes, owns the PC and a saturating
// retired-instruction counter.
// Optional feature: define CPU_CTRL_BRANCH_EN to make opcode 4'hE a
// zero-flag conditional branch; otherwise 4'hE behaves as a NOP.
module cpu_ctrl #(
  parameter int PC_W     = 6,
  parameter int PC_STEP  = 2,
  parameter int RESET_PC = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic [31:0]     instr,
  input  logic            imem_valid,
  input  logic            alu_zero,
  output logic [PC_W-1:0] pc,
  output logic            fetch_req,
  output logic            decode_en,
  output logic            alu_en,
  output logic            reg_write,
  output logic            halted,
  output logic [2:0]      state,
  output logic [15:0]     instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_BZ   = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t          r_state, w_next;
  logic [31:0]     r_instr;
  logic [PC_W-1:0] r_pc;
  logic [15:0]     r_cnt;
  logic            r_z;

  logic [3:0]      w_op;
  logic            w_is_halt, w_is_alu;
  logic            w_done, w_retire, w_taken;
  logic [PC_W-1:0] w_pc_next;
  logic            w_unused;

  assign w_op      = r_instr[31:28];
  assign w_is_halt = (w_op == OP_HALT);
  assign w_is_alu  = (w_op != OP_HALT) && (w_op != OP_BZ) && (w_op != OP_NOP);

  // An instruction completes when it leaves EXEC (non-ALU) or WB (ALU).
  assign w_done    = ((r_state == S_EXEC) && !w_is_alu) || (r_state == S_WB);
  // HALT also retires, as it leaves DECODE.
  assign w_retire  = w_done || ((r_state == S_DECODE) && w_is_halt);

`ifdef CPU_CTRL_BRANCH_EN
  assign w_taken   = (r_state == S_EXEC) && (w_op == OP_BZ) && r_z;
`else
  assign w_taken   = 1'b0;
`endif

  assign w_pc_next = w_taken ? r_instr[PC_W-1:0] : r_pc + PC_W'(PC_STEP);

  // Bits of the latched word that only matter in some builds.
  assign w_unused  = ^{r_instr, r_z};

  // State register; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (run) w_next = S_FETCH;
      S_FETCH:  if (imem_valid) w_next = S_DECODE;
      S_DECODE: w_next = w_is_halt ? S_HALT : S_EXEC;
      S_EXEC:   if (w_is_alu) w_next = S_WB;
                else          w_next = run ? S_FETCH : S_IDLE;
      S_WB:     w_next = run ? S_FETCH : S_IDLE;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_IDLE;
    endcase
  end

  // Instruction latch, captured on the accepted fetch.
  always_ff @(posedge clk) begin
    if (reset)                                 r_instr <= '0;
    else if ((r_state == S_FETCH) && imem_valid) r_instr <= instr;
  end

  // Zero flag is sampled while an ALU op is executing.
  always_ff @(posedge clk) begin
    if (reset)                               r_z <= 1'b0;
    else if ((r_state == S_EXEC) && w_is_alu) r_z <= alu_zero;
  end

  // PC advances (or branches) on completion; HALT leaves it frozen.
  always_ff @(posedge clk) begin
    if (reset)       r_pc <= PC_W'(RESET_PC);
    else if (w_done) r_pc <= w_pc_next;
  end

  // Saturating retired-instruction counter.
  always_ff @(posedge clk) begin
    if (reset)                           r_cnt <= '0;
    else if (w_retire && (r_cnt != 16'hFFFF)) r_cnt <= r_cnt + 16'd1;
  end

  assign pc          = r_pc;
  assign state       = r_state;
  assign instr_count = r_cnt;
  assign fetch_req   = (r_state == S_FETCH);
  assign decode_en   = (r_state == S_DECODE);
  assign alu_en      = (r_state == S_EXEC);
  assign reg_write   = (r_state == S_WB);
  assign halted      = (r_state == S_HALT);

endmodule

// File: tb/tb_cpu_ctrl.sv
// Self-checking bench for cpu_ctrl: directed scenarios plus randomized
// instruction streams checked against a per-instruction reference model.
module tb_cpu_ctrl;
  logic        clk = 1'b0;
  logic        reset, run, imem_valid, alu_zero;
  logic [31:0] instr;
  logic [5:0]  pc;
  logic        fetch_req, decode_en, alu_en, reg_write, halted;
  logic [2:0]  state;
  logic [15:0] instr_count;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [5:0] exp_pc;
  int         exp_cnt;
  bit         exp_z;

  cpu_ctrl #(.PC_W(6), .PC_STEP(2), .RESET_PC(0)) dut (
    .clk(clk), .reset(reset), .run(run), .instr(instr),
    .imem_valid(imem_valid), .alu_zero(alu_zero), .pc(pc),
    .fetch_req(fetch_req), .decode_en(decode_en), .alu_en(alu_en),
    .reg_write(reg_write), .halted(halted), .state(state),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] alu_word();
    logic [3:0] op;
    op = 4'($urandom_range(1, 13));
    return {op, 28'($urandom)};
  endfunction

  function automatic logic [31:0] nop_word();
    return {4'h0, 28'($urandom)};
  endfunction

  // Issue one instruction starting from FETCH; checks timing, strobes and
  // the architectural result against the model.
  task automatic do_instr(input logic [31:0] w, input bit az, input int wait_cyc,
                          input bit drop_run);
    int n, nd, na, nr, exp_n;
    logic [3:0] op;
    bit is_halt, is_alu;
    op      = w[31:28];
    is_halt = (op == 4'hF);
    is_alu  = !(op == 4'h0 || op == 4'hE || op == 4'hF);
    chk("start_state", 32'(state), 32'd1);
    chk("start_pc", 32'(pc), 32'(exp_pc));
    imem_valid = 1'b0;
    instr      = $urandom;
    alu_zero   = 1'($urandom);
    for (int i = 0; i < wait_cyc; i++) begin
      tick;
      chk("wait_state", 32'(state), 32'd1);
      chk("wait_strobes", 32'({fetch_req, decode_en, alu_en, reg_write, halted}), 32'b10000);
      chk("wait_pc", 32'(pc), 32'(exp_pc));
    end
    imem_valid = 1'b1;
    instr      = w;
    alu_zero   = az;
    nd = 0; na = 0; nr = 0;
    tick;
    n = 1;
    imem_valid = 1'b0;
    instr      = $urandom;
    if (drop_run) run = 1'b0;
    while ((state == 3'd2 || state == 3'd3 || state == 3'd4) && n < 10) begin
      nd += int'(decode_en);
      na += int'(alu_en);
      nr += int'(reg_write);
      tick;
      n++;
    end
    // model
    exp_cnt++;
    if (is_halt) begin
      exp_n = 2;
    end else if (is_alu) begin
      exp_n  = 4;
      exp_z  = az;
      exp_pc = exp_pc + 6'd2;
    end else begin
      exp_n = 3;
`ifdef CPU_CTRL_BRANCH_EN
      if (op == 4'hE && exp_z) exp_pc = w[5:0];
      else                     exp_pc = exp_pc + 6'd2;
`else
      exp_pc = exp_pc + 6'd2;
`endif
    end
    chk("cycles", 32'(n), 32'(exp_n));
    chk("end_state", 32'(state), is_halt ? 32'd5 : (drop_run ? 32'd0 : 32'd1));
    chk("pc", 32'(pc), 32'(exp_pc));
    chk("instr_count", 32'(instr_count), 32'(exp_cnt));
    chk("decode_pulses", 32'(nd), 32'd1);
    chk("alu_pulses", 32'(na), is_halt ? 32'd0 : 32'd1);
    chk("regwr_pulses", 32'(nr), is_alu ? 32'd1 : 32'd0);
  endtask

  initial begin
    logic [31:0] w;
    int k;
    reset = 1'b1; run = 1'b1; imem_valid = 1'b1; instr = 32'h1000_0000; alu_zero = 1'b0;
    exp_pc = 6'd0; exp_cnt = 0; exp_z = 1'b0;

    // reset holds IDLE even with run and imem_valid high
    tick; tick;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_strobes", 32'({fetch_req, decode_en, alu_en, reg_write, halted}), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_count", 32'(instr_count), 32'd0);
    reset = 1'b0; run = 1'b0; imem_valid = 1'b0;
    tick;
    chk("idle_hold", 32'(state), 32'd0);
    run = 1'b1;
    tick;

    // three back-to-back ALU ops: pc 0,2,4 -> 6, 4-cycle spacing
    for (int i = 0; i < 3; i++) do_instr(alu_word(), 1'b0, 0, 1'b0);
    chk("three_alu_pc", 32'(pc), 32'd6);
    chk("three_alu_cnt", 32'(instr_count), 32'd3);

    // fetch stall of 5 cycles
    do_instr(nop_word(), 1'b0, 5, 1'b0);

    // ALU sets zero flag, then BZ to 0x10
    do_instr(alu_word(), 1'b1, 0, 1'b0);
    w = {4'hE, 22'($urandom), 6'h10};
    do_instr(w, 1'b0, 0, 1'b0);

    // randomized stream (even branch targets keep pc even)
    for (int i = 0; i < 30; i++) begin
      k = $urandom_range(0, 2);
      if (k == 0)      w = nop_word();
      else if (k == 1) w = {4'hE, 22'($urandom), 5'($urandom), 1'b0};
      else             w = alu_word();
      do_instr(w, 1'($urandom), $urandom_range(0, 3), 1'b0);
    end

    // pc wrap 62 -> 0
    k = 0;
    while (exp_pc != 6'd62 && k < 40) begin
      do_instr(nop_word(), 1'b0, 0, 1'b0);
      k++;
    end
    chk("at_62", 32'(pc), 32'd62);
    do_instr(alu_word(), 1'b0, 0, 1'b0);
    chk("wrap_pc", 32'(pc), 32'd0);

    // run dropped in DECODE: instruction completes, then IDLE
    do_instr(alu_word(), 1'b0, 0, 1'b1);
    tick;
    chk("drop_idle_hold", 32'(state), 32'd0);
    run = 1'b1;
    tick;
    chk("drop_resume", 32'(state), 32'd1);

    // reset asserted during EXEC
    imem_valid = 1'b1; instr = alu_word();
    tick;
    imem_valid = 1'b0;
    tick;
    chk("in_exec", 32'(state), 32'd3);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    exp_pc = 6'd0; exp_cnt = 0; exp_z = 1'b0;
    chk("exec_rst_state", 32'(state), 32'd0);
    chk("exec_rst_strobes", 32'({fetch_req, decode_en, alu_en, reg_write, halted}), 32'd0);
    chk("exec_rst_count", 32'(instr_count), 32'd0);
    chk("exec_rst_pc", 32'(pc), 32'd0);
    tick;

    // HALT at pc=4, frozen regardless of inputs, reset recovers
    do_instr(nop_word(), 1'b0, 0, 1'b0);
    do_instr(nop_word(), 1'b0, 0, 1'b0);
    do_instr({4'hF, 28'($urandom)}, 1'b0, 0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      run = 1'($urandom); imem_valid = 1'($urandom); instr = $urandom;
      tick;
      chk("halt_state", 32'(state), 32'd5);
      chk("halt_strobes", 32'({fetch_req, decode_en, alu_en, reg_write, halted}), 32'b00001);
      chk("halt_pc", 32'(pc), 32'd4);
      chk("halt_count", 32'(instr_count), 32'(exp_cnt));
    end
    reset = 1'b1;
    tick;
    reset = 1'b0; run = 1'b0; imem_valid = 1'b0;
    chk("halt_rst_state", 32'(state), 32'd0);
    chk("halt_rst_pc", 32'(pc), 32'd0);
    chk("halt_rst_halted", 32'(halted), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_ctrl.md
CPU_CTRL -- requirements
Module: cpu_ctrl

Interface
REQ-001 SHALL have parameter PC_W, default 6, program-counter width.
REQ-002 SHALL have parameter PC_STEP, default 2, PC increment per instruction.
REQ-003 SHALL have parameter RESET_PC, default 0, PC value after reset.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port reset  input  1  synchronous active-high reset.
REQ-007 SHALL have port run  input  1  level; permits fetching new instructions.
REQ-008 SHALL have port instr  input  32  instruction word from instruction memory.
REQ-009 SHALL have port imem_valid  input  1  instr valid this cycle.
REQ-010 SHALL have port alu_zero  input  1  ALU zero result.
REQ-011 SHALL have port pc  output  PC_W  current fetch address.
REQ-012 SHALL have port fetch_req  output  1  instruction fetch request.
REQ-013 SHALL have port decode_en  output  1  decode-stage enable.
REQ-014 SHALL have port alu_en  output  1  execute-stage enable.
REQ-015 SHALL have port reg_write  output  1  register-file write strobe.
REQ-016 SHALL have port halted  output  1  HALT executed.
REQ-017 SHALL have port state  output  3  FSM state code.
REQ-018 SHALL have port instr_count  output  16  retired-instruction count.

Function
REQ-019 SHALL implement states IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, HALT=5; codes 6-7 SHALL return to IDLE next cycle.
REQ-020 SHALL move IDLE->FETCH when run=1; otherwise hold IDLE.
REQ-021 SHALL hold fetch_req=1 in FETCH, latch instr and move to DECODE on the cycle imem_valid=1; otherwise wait in FETCH indefinitely.
REQ-022 SHALL assert decode_en only in DECODE, alu_en only in EXEC, and reg_write only in WB; each is a 1-cycle pulse.
REQ-023 SHALL decode opcode = latched instr[31:28]: 4'hF HALT, 4'hE BZ, 4'h0 NOP, all others ALU.
REQ-024 SHALL, for ALU, go EXEC->WB, pulse reg_write, and latch alu_zero into internal z_flag in EXEC.
REQ-025 SHALL, for NOP and BZ, go EXEC->FETCH or EXEC->IDLE per REQ-028, with no WB cycle and no reg_write.
REQ-026 SHALL, for HALT, go DECODE->HALT; HALT is held until reset; run and imem_valid are ignored; halted=1 while in HALT.
REQ-027 SHALL update pc when the instruction leaves EXEC (non-ALU) or WB (ALU): pc+PC_STEP modulo 2^PC_W (e.g. 62->0 at PC_W=6), except for a taken branch.
REQ-028 SHALL, at instruction completion, go to FETCH if run=1 else IDLE; deasserting run mid-instruction completes that instruction.
REQ-029 SHALL increment instr_count at each completion (ALU, NOP, BZ, HALT); it saturates at 16'hFFFF.
REQ-030 SHALL give a minimum latency (imem_valid already high) of 4 cycles for ALU and 3 cycles for NOP/BZ, from FETCH entry to the next FETCH entry.

Reset
REQ-031 SHALL, on reset=1 at a clock edge and in any state, set state=IDLE, pc=RESET_PC, instr_count=0, z_flag=0, latched instr=0, and halted=fetch_req=decode_en=alu_en=reg_write=0.
REQ-032 SHALL give reset priority over every other event, including a pending imem_valid.

Configuration
REQ-033 SHALL, with CPU_CTRL_BRANCH_EN defined, treat BZ as: if z_flag=1, pc <= latched instr[PC_W-1:0] (the branch is taken), else pc+PC_STEP.
REQ-034 SHALL, without CPU_CTRL_BRANCH_EN, treat opcode 4'hE as NOP; pc always advances by PC_STEP.

Verification
REQ-035 SHALL test: reset, run=1, imem_valid=1, 3 ALU instrs -> pc 0,2,4,6; reg_write pulses 3 times at 4-cycle spacing; instr_count=3.
REQ-036 SHALL test: imem_valid held low 5 cycles in FETCH -> state=1 and fetch_req=1 throughout; no other strobes; pc unchanged.
REQ-037 SHALL test: ALU with alu_zero=1 then BZ with target 6'h10 (BRANCH_EN defined) -> pc=0x10; without the macro -> pc=prev+2.
REQ-038 SHALL test: HALT at pc=4 -> halted=1, state=5, pc=4 frozen for 20 cycles regardless of run; reset -> IDLE, pc=0.
REQ-039 SHALL test: pc=62 with an ALU instr -> next pc=0.
REQ-040 SHALL test: reset asserted in EXEC -> next cycle state=0, all strobes 0, instr_count=0; and run dropped in DECODE -> instruction completes, then state=IDLE.
